// File: rtl/sdram_tester_pkg.sv
// Shared types and constants for the SDRAM built-in memory tester.
package sdram_tester_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_WAIT,
    S_RD_REQ,
    S_RD_WAIT,
    S_DONE,
    S_ABORT
  } tester_state_e;

  // x^16+x^14+x^13+x^11+1 in right-shift Fibonacci form: feedback from bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS          = 16'h002D;
  localparam logic [15:0] DEF_SEED           = 16'hACE1;
  localparam int          DEF_TIMEOUT_CYCLES = 1024;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/sdram_lfsr16.sv
// 16-bit pattern generator; one instance serves both write and read passes.
module sdram_lfsr16
  import sdram_tester_pkg::*;
#(
  parameter logic [15:0] SEED = DEF_SEED
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        advance_i,
  output logic [15:0] value_o
);

  logic [15:0] lfsr_q;

  // Reload wins over advance so the last ack of a pass restarts the sequence.
  always_ff @(posedge clk_i) begin
    if (rst_i)          lfsr_q <= SEED;
    else if (load_i)    lfsr_q <= SEED;
    else if (advance_i) lfsr_q <= lfsr_next(lfsr_q);
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/sdram_mem_tester.sv
// Write-then-verify LFSR memory test master for the SDRAM controller request port.
// Define MEM_TESTER_INVERT_PASS_EN to add a second pass using the inverted pattern.
module sdram_mem_tester
  import sdram_tester_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 25,
  parameter int          DATA_WIDTH     = 16,
  parameter int unsigned START_ADDR     = 0,
  parameter int unsigned END_ADDR       = 2**25-1,
  parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [15:0] SEED           = DEF_SEED
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  start_i,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic [15:0]           error_count_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  mem_we_o,
  output logic                  mem_re_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic                  mem_ack_i,
  input  logic                  mem_busy_i
);

  localparam logic [ADDR_WIDTH-1:0] A_FIRST  = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] A_LAST   = ADDR_WIDTH'(END_ADDR);
  localparam int                    TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]         TMO_LOAD = TW'(TIMEOUT_CYCLES);

  tester_state_e         state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [TW-1:0]         tmo_q;
  logic [15:0]           lfsr, pat, err_cnt_d;
  logic                  acked, last, start_ok, mismatch;

  sdram_lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk_i     (sys_clk),
    .rst_i     (sys_rst),
    .load_i    (start_ok || (acked && last)),
    .advance_i (acked),
    .value_o   (lfsr)
  );

`ifdef MEM_TESTER_INVERT_PASS_EN
  logic inv_q;
  assign pat = inv_q ? ~lfsr : lfsr;
`else
  assign pat = lfsr;
`endif

  assign acked    = mem_ack_i && (state_q == S_WR_WAIT || state_q == S_RD_WAIT);
  assign last     = addr_q == A_LAST;
  assign start_ok = start_i && (state_q inside {S_IDLE, S_DONE, S_ABORT});
  assign mismatch = mem_ack_i && state_q == S_RD_WAIT && (mem_data_i != pat);
  assign err_cnt_d = (mismatch && error_count_o != 16'hFFFF) ? error_count_o + 16'd1
                                                             : error_count_o;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q          <= S_IDLE;
      addr_q           <= '0;
      tmo_q            <= '0;
      done_o           <= 1'b0;
      pass_o           <= 1'b0;
      timeout_o        <= 1'b0;
      error_count_o    <= '0;
      first_err_addr_o <= '0;
      mem_addr_o       <= '0;
      mem_data_o       <= '0;
      mem_we_o         <= 1'b0;
      mem_re_o         <= 1'b0;
`ifdef MEM_TESTER_INVERT_PASS_EN
      inv_q            <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE, S_ABORT: if (start_i) begin
          done_o           <= 1'b0;
          pass_o           <= 1'b0;
          timeout_o        <= 1'b0;
          error_count_o    <= '0;
          first_err_addr_o <= '0;
          addr_q           <= A_FIRST;
          state_q          <= S_WR_REQ;
`ifdef MEM_TESTER_INVERT_PASS_EN
          inv_q            <= 1'b0;
`endif
        end
        S_WR_REQ: if (!mem_busy_i) begin
          mem_we_o   <= 1'b1;
          mem_addr_o <= addr_q;
          mem_data_o <= pat;
          tmo_q      <= TMO_LOAD;
          state_q    <= S_WR_WAIT;
        end
        S_RD_REQ: if (!mem_busy_i) begin
          mem_re_o   <= 1'b1;
          mem_addr_o <= addr_q;
          tmo_q      <= TMO_LOAD;
          state_q    <= S_RD_WAIT;
        end
        S_WR_WAIT, S_RD_WAIT: begin
          if (mem_ack_i) begin
            mem_we_o <= 1'b0;
            mem_re_o <= 1'b0;
            addr_q   <= last ? A_FIRST : addr_q + 1'b1;
            if (state_q == S_WR_WAIT) begin
              state_q <= last ? S_RD_REQ : S_WR_REQ;
            end else begin
              error_count_o <= err_cnt_d;
              if (mismatch && error_count_o == '0) first_err_addr_o <= addr_q;
              if (!last) state_q <= S_RD_REQ;
`ifdef MEM_TESTER_INVERT_PASS_EN
              else if (!inv_q) begin
                inv_q   <= 1'b1;
                state_q <= S_WR_REQ;
              end
`endif
              else begin
                state_q <= S_DONE;
                done_o  <= 1'b1;
                pass_o  <= (err_cnt_d == '0);
              end
            end
          end else if (tmo_q <= TW'(1)) begin
            // No ack within the budget: the controller is wedged, give up.
            mem_we_o  <= 1'b0;
            mem_re_o  <= 1'b0;
            timeout_o <= 1'b1;
            done_o    <= 1'b1;
            pass_o    <= 1'b0;
            state_q   <= S_ABORT;
          end else begin
            tmo_q <= tmo_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_mem_tester.sv
// Randomized bench: two tester instances (window 0..3 and 7..7) against a reactive SDRAM model.
module tb_sdram_mem_tester;

  localparam int AW = 25;
  localparam logic [15:0] SEED_TB = 16'hACE1;
`ifdef MEM_TESTER_INVERT_PASS_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start [2];
  logic          done [2], pass [2], tmo [2], we [2], re [2], ack [2], busy [2];
  logic [15:0]   errc [2], dout [2], din [2];
  logic [AW-1:0] ferr [2], addr [2];

  // model configuration (bench-written)
  int          lat_c [2], busy_c [2], corr_c [2], drop_c [2], run_id [2];
  logic [15:0] mask_c [2];
  // model state (model-written)
  int            seen [2], nacc [2], viol [2], lat [2], bcnt [2], cyc_drop [2];
  logic          pend [2], prev_req [2];
  logic [15:0]   mem [2][8];
  logic [AW-1:0] laddr [2][32];
  logic          lwe [2][32];
  logic [15:0]   ldata [2][32];

  int cyc = 0;
  int done_cyc;
  int n_chk, n_err;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : gi
    sdram_mem_tester #(
      .START_ADDR     ((g == 0) ? 0 : 7),
      .END_ADDR       ((g == 0) ? 3 : 7),
      .TIMEOUT_CYCLES (16)
    ) dut (
      .sys_clk          (clk),
      .sys_rst          (rst),
      .start_i          (start[g]),
      .done_o           (done[g]),
      .pass_o           (pass[g]),
      .timeout_o        (tmo[g]),
      .error_count_o    (errc[g]),
      .first_err_addr_o (ferr[g]),
      .mem_addr_o       (addr[g]),
      .mem_data_o       (dout[g]),
      .mem_we_o         (we[g]),
      .mem_re_o         (re[g]),
      .mem_data_i       (din[g]),
      .mem_ack_i        (ack[g]),
      .mem_busy_i       (busy[g])
    );
  end

  // Controller model: fixed ack latency per run, busy window after each ack and at run start.
  always @(negedge clk) begin : model
    int nb;
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        ack[g] <= 1'b0; busy[g] <= 1'b0; din[g] <= '0;
        pend[g] <= 1'b0; prev_req[g] <= 1'b0; bcnt[g] <= 0;
      end else begin
        nb = bcnt[g];
        ack[g] <= 1'b0;
        if (seen[g] != run_id[g]) begin
          seen[g] <= run_id[g]; nacc[g] <= 0; viol[g] <= 0; cyc_drop[g] <= -1;
          nb = busy_c[g];
        end else if ((we[g] || re[g]) && !prev_req[g]) begin
          if (busy[g] || (we[g] && re[g])) viol[g] <= viol[g] + 1;
          if (nacc[g] < 32) begin
            laddr[g][nacc[g]] <= addr[g];
            lwe[g][nacc[g]]   <= we[g];
            ldata[g][nacc[g]] <= dout[g];
          end
          if (nacc[g] == drop_c[g]) cyc_drop[g] <= cyc;
          else begin pend[g] <= 1'b1; lat[g] <= lat_c[g]; end
          nacc[g] <= nacc[g] + 1;
        end else if (pend[g]) begin
          if (lat[g] <= 1) begin
            pend[g] <= 1'b0; ack[g] <= 1'b1; nb = busy_c[g];
            if (we[g]) mem[g][addr[g][2:0]] <= dout[g];
            else din[g] <= mem[g][addr[g][2:0]] ^ ((int'(addr[g]) == corr_c[g]) ? mask_c[g] : 16'h0);
          end else lat[g] <= lat[g] - 1;
        end
        prev_req[g] <= we[g] || re[g];
        busy[g]     <= nb > 0;
        bcnt[g]     <= (nb > 0) ? nb - 1 : 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    int unsigned v, fb;
    v  = s;
    fb = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
    return 16'((v >> 1) | (fb << 15));
  endfunction

  function automatic int w_first(input int g); return (g == 0) ? 0 : 7; endfunction
  function automatic int w_last(input int g);  return (g == 0) ? 3 : 7; endfunction

  task automatic kick(input int g, input int l, input int b, input int corr,
                      input logic [15:0] mask, input int drop);
    lat_c[g] = l; busy_c[g] = b; corr_c[g] = corr; mask_c[g] = mask; drop_c[g] = drop;
    run_id[g]++;
    @(negedge clk) start[g] = 1'b1;
    @(negedge clk) start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done[g]) break;
    end
    chk("done_within_budget", done[g], 1);
    done_cyc = cyc;
  endtask

  task automatic check_reset(input int g);
    chk("rst_done", done[g], 0);   chk("rst_pass", pass[g], 0);
    chk("rst_timeout", tmo[g], 0); chk("rst_errcnt", errc[g], 0);
    chk("rst_ferr", ferr[g], 0);   chk("rst_we", we[g], 0);
    chk("rst_re", re[g], 0);       chk("rst_addr", addr[g], 0);
    chk("rst_wdata", dout[g], 0);
  endtask

  // Expected traffic: every pass writes the window in order with the LFSR
  // sequence from SEED (inverted on the second pass), then reads it back.
  task automatic check_run(input int g, input int corr, input logic [15:0] mask);
    logic [15:0] s, w;
    int k, exp_err, exp_ferr;
    k = 0; exp_err = 0; exp_ferr = 0;
    for (int p = 0; p < NPASS; p++) begin
      s = SEED_TB;
      for (int a = w_first(g); a <= w_last(g); a++) begin
        w = (p == 1) ? ~s : s;
        chk("wr_addr", laddr[g][k], a); chk("wr_is_write", lwe[g][k], 1);
        chk("wr_data", ldata[g][k], w);
        k++; s = lfsr_step(s);
      end
      for (int a = w_first(g); a <= w_last(g); a++) begin
        chk("rd_addr", laddr[g][k], a); chk("rd_is_read", lwe[g][k], 0);
        if (a == corr && mask != 16'h0) begin
          if (exp_err == 0) exp_ferr = a;
          exp_err++;
        end
        k++;
      end
    end
    chk("n_access", nacc[g], k);
    chk("err_count", errc[g], exp_err);
    chk("first_err_addr", ferr[g], exp_ferr);
    chk("pass", pass[g], (exp_err == 0) ? 1 : 0);
    chk("timeout", tmo[g], 0);
    chk("req_while_busy", viol[g], 0);
    chk("req_idle", we[g] | re[g], 0);
  endtask

  initial begin
    int g, corr, stall;
    n_chk = 0; n_err = 0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; lat_c[i] = 4; busy_c[i] = 0; corr_c[i] = -1;
      mask_c[i] = '0; drop_c[i] = -1; run_id[i] = 0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset(0); check_reset(1);
    rst = 1'b0;

    // clean pass, 4-cycle memory
    kick(0, 4, 0, -1, 16'h0, -1); wait_done(0, 2000); check_run(0, -1, 16'h0);
    // bit 0 flipped on read of addr 2
    kick(0, 4, 0, 2, 16'h0001, -1); wait_done(0, 2000); check_run(0, 2, 16'h0001);
    // 50-cycle refresh before every request
    kick(0, 4, 50, -1, 16'h0, -1); wait_done(0, 4000); check_run(0, -1, 16'h0);

    // second write never acked
    kick(0, 4, 0, -1, 16'h0, 1); wait_done(0, 300);
    chk("to_timeout", tmo[0], 1); chk("to_pass", pass[0], 0);
    chk("to_we", we[0], 0);       chk("to_re", re[0], 0);
    chk("to_n_access", nacc[0], 2);
    chk("to_latency", done_cyc - cyc_drop[0], 16);

    // reset in the middle of the write pass, then restart from ABORT-cleared state
    kick(0, 4, 0, -1, 16'h0, -1);
    for (int i = 0; i < 300 && nacc[0] < 2; i++) @(negedge clk);
    chk("midrst_progress", nacc[0] >= 2, 1);
    rst = 1'b1;
    @(negedge clk) check_reset(0);
    @(negedge clk) rst = 1'b0;
    kick(0, 4, 0, -1, 16'h0, -1); wait_done(0, 2000); check_run(0, -1, 16'h0);

    // single-word window, start pulsed while the read is outstanding
    kick(1, 6, 0, -1, 16'h0, -1);
    for (int i = 0; i < 300 && !re[1]; i++) @(negedge clk);
    chk("single_rd_seen", re[1], 1);
    start[1] = 1'b1;
    @(negedge clk) start[1] = 1'b0;
    wait_done(1, 2000); check_run(1, -1, 16'h0);

    // randomized latency / busy / corruption
    for (int it = 0; it < 10; it++) begin
      g     = $urandom_range(0, 1);
      corr  = ($urandom_range(0, 1) == 1) ? $urandom_range(w_first(g), w_last(g)) : -1;
      stall = $urandom_range(0, 6);
      mask_c[g] = 16'(1 << $urandom_range(0, 15));
      kick(g, $urandom_range(1, 8), stall, corr, mask_c[g], -1);
      wait_done(g, 3000);
      check_run(g, corr, mask_c[g]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
